// File: rtl/stage_mem_access_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM states, MCR field
// positions and the funct3 load encodings.
package stage_mem_access_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_REQ_W   = 5'b00010,
    ST_REQ_R   = 5'b00100,
    ST_WAIT_RD = 5'b01000,
    ST_DONE    = 5'b10000
  } state_t;

  localparam int MCR_MEMW    = 5;
  localparam int MCR_MEMR    = 4;
  localparam int MCR_STRB_HI = 3;
  localparam int MCR_STRB_LO = 0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/stage_mem_access_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// data memory (slave).
interface stage_mem_access_if;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  modport master (
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    input  Mem_Req_Ready, Read_data, Read_data_Valid
  );

  modport slave (
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    output Mem_Req_Ready, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/stage_mem_access_load_extract.sv
// Selects the addressed byte/half/word from a loaded word and sign- or
// zero-extends it according to funct3.
module load_extract
  import stage_mem_access_pkg::*;
(
  input  logic [31:0] rdr,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = rdr >> {off, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = off[1] ? rdr[31:16] : rdr[15:0];

  always_comb begin
    // NOTE: every branch assigns result, and the default covers the
    // remaining funct3 codes, so no latch is inferred.
    case (f3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = rdr;
    endcase
  end

endmodule

// File: rtl/stage_mem_access.sv
// MEM pipeline stage: issues data-memory requests for loads/stores, stalls
// EX while an access is outstanding, and registers the result for WB.
module stage_mem_access
  import stage_mem_access_pkg::*;
#(
  parameter bit ALIGN_ADDR = 1'b1
) (
  input  logic                      clk_I,
  input  logic                      rst_n,
  input  logic                      Done_I,
  input  logic [31:0]               PC_I,
  input  logic [5:0]                MCR,
  input  logic [31:0]               WDR,
  input  logic [31:0]               ASR,
  input  logic [4:0]                RAR,
  input  logic [2:0]                F3R,
  stage_mem_access_if.master        mem,
  output logic                      Feedback_Mem_Acc,
  output logic                      Done_O,
  output logic [31:0]               PC_O,
  output logic [4:0]                RF_waddr_O,
  output logic [31:0]               RF_wdata_O
);

  state_t      state, state_next;
  logic        memop;
  logic        is_store;
  logic [31:0] rdr;
  logic [31:0] load_data;

  assign is_store = MCR[MCR_MEMW];
  assign memop    = Done_I & (MCR[MCR_MEMW] | MCR[MCR_MEMR]);

  assign mem.Address    = ALIGN_ADDR ? {ASR[31:2], 2'b00} : ASR;
  assign mem.Write_data = WDR;
  assign mem.Write_strb = MCR[MCR_STRB_HI:MCR_STRB_LO];

  load_extract u_load_extract (
    .rdr    (rdr),
    .off    (ASR[1:0]),
    .f3     (F3R),
    .result (load_data)
  );

  always_ff @(posedge clk_I or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (memop) state_next = is_store ? ST_REQ_W : ST_REQ_R;
      end
      ST_REQ_W:   if (mem.Mem_Req_Ready)   state_next = ST_DONE;
      ST_REQ_R:   if (mem.Mem_Req_Ready)   state_next = ST_WAIT_RD;
      ST_WAIT_RD: if (mem.Read_data_Valid) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Moore decode only; the stall uses EX registers but no memory inputs so
  // the EX clock gate never sees a glitch from the bus.
  always_comb begin
    mem.MemWrite        = (state == ST_REQ_W);
    mem.MemRead         = (state == ST_REQ_R);
    mem.Read_data_Ready = (state == ST_WAIT_RD);
    Feedback_Mem_Acc    = ((state == ST_IDLE) & memop) |
                          (state == ST_REQ_W) | (state == ST_REQ_R) |
                          (state == ST_WAIT_RD);
  end

  always_ff @(posedge clk_I or negedge rst_n) begin
    // NOTE: rdr is a single register, not an array, so it is cleared on
    // reset like the rest of the datapath.
    if (!rst_n) begin
      Done_O     <= 1'b0;
      PC_O       <= '0;
      RF_waddr_O <= '0;
      RF_wdata_O <= '0;
      rdr        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (memop) begin
            Done_O <= 1'b0;
          end else begin
            Done_O <= Done_I;
            if (Done_I) begin
              PC_O       <= PC_I;
              RF_waddr_O <= RAR;
              RF_wdata_O <= ASR;
            end
          end
        end
        ST_WAIT_RD: begin
          Done_O <= 1'b0;
          if (mem.Read_data_Valid) rdr <= mem.Read_data;
        end
        ST_DONE: begin
          Done_O     <= 1'b1;
          PC_O       <= PC_I;
          RF_waddr_O <= RAR;
          RF_wdata_O <= is_store ? ASR : load_data;
        end
        default: Done_O <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem_access.sv
// Directed bench for stage_mem_access: EX driver, memory responder model and
// a write-back scoreboard.
module tb_stage_mem_access;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  logic        clk;
  logic        rst_n;
  logic        Done_I;
  logic [31:0] PC_I;
  logic [5:0]  MCR;
  logic [31:0] WDR;
  logic [31:0] ASR;
  logic [4:0]  RAR;
  logic [2:0]  F3R;
  logic        Feedback_Mem_Acc;
  logic        Done_O;
  logic [31:0] PC_O;
  logic [4:0]  RF_waddr_O;
  logic [31:0] RF_wdata_O;

  stage_mem_access_if mem_if ();

  stage_mem_access #(.ALIGN_ADDR(1'b1)) dut (
    .clk_I            (clk),
    .rst_n            (rst_n),
    .Done_I           (Done_I),
    .PC_I             (PC_I),
    .MCR              (MCR),
    .WDR              (WDR),
    .ASR              (ASR),
    .RAR              (RAR),
    .F3R              (F3R),
    .mem              (mem_if.master),
    .Feedback_Mem_Acc (Feedback_Mem_Acc),
    .Done_O           (Done_O),
    .PC_O             (PC_O),
    .RF_waddr_O       (RF_waddr_O),
    .RF_wdata_O       (RF_wdata_O)
  );

  logic [31:0] ref_rdr;
  logic [1:0]  ref_off;
  logic [2:0]  ref_f3;
  logic [31:0] ref_result;

  load_extract u_ref (
    .rdr    (ref_rdr),
    .off    (ref_off),
    .f3     (ref_f3),
    .result (ref_result)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  wb_t sb[$];
  int  done_count = 0;

  // memory model knobs
  int          req_delay  = 1;
  int          rd_delay   = 1;
  logic [31:0] rd_word    = 32'h0;
  bit          spur_ready = 1'b0;
  bit          spur_valid = 1'b0;
  int          req_cnt    = 0;
  int          rd_cnt     = 0;
  int          accepts    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: evaluates 2 time units after each rising edge.
  initial begin
    mem_if.Mem_Req_Ready   = 1'b0;
    mem_if.Read_data_Valid = 1'b0;
    mem_if.Read_data       = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    #2;
    if (mem_if.MemWrite || mem_if.MemRead) req_cnt++;
    else                                   req_cnt = 0;
    mem_if.Mem_Req_Ready = (req_cnt != 0) ? (req_cnt >= req_delay) : spur_ready;
    if (mem_if.Mem_Req_Ready && (mem_if.MemWrite || mem_if.MemRead)) accepts++;
    if (mem_if.Read_data_Ready) begin
      rd_cnt++;
      mem_if.Read_data       = rd_word;
      mem_if.Read_data_Valid = (rd_cnt >= rd_delay);
    end else begin
      rd_cnt = 0;
      mem_if.Read_data       = 32'hDEAD_BEEF;
      mem_if.Read_data_Valid = spur_valid;
    end
  end

  // Write-back monitor: pops the scoreboard on every Done_O.
  always @(posedge clk) begin
    #1;
    if (Done_O === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        check("wb_unexpected_done", 32'(Done_O), 32'd0);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("wb_pc", PC_O, e.pc);
        check("wb_waddr", 32'(RF_waddr_O), 32'(e.waddr));
        check("wb_wdata", RF_wdata_O, e.wdata);
      end
    end
  end

  // Presents one instruction from EX and holds it until EX is allowed to
  // advance. Starts and ends at a falling edge.
  task automatic issue(input logic [31:0] pc, input logic [5:0] mcr,
                       input logic [31:0] wdr, input logic [31:0] asr,
                       input logic [4:0] rar, input logic [2:0] f3,
                       input logic [31:0] exp_wdata,
                       output int fb_cyc, output int mw_cyc, output int mr_cyc);
    bit adv;
    wb_t e;
    Done_I = 1'b1; PC_I = pc; MCR = mcr; WDR = wdr; ASR = asr; RAR = rar; F3R = f3;
    e.pc = pc; e.waddr = rar; e.wdata = exp_wdata;
    sb.push_back(e);
    fb_cyc = 0; mw_cyc = 0; mr_cyc = 0; adv = 1'b0;
    for (int n = 0; n < 64 && !adv; n++) begin
      #1;
      if (Feedback_Mem_Acc) fb_cyc++;
      else                  adv = 1'b1;
      if (mem_if.MemWrite) mw_cyc++;
      if (mem_if.MemRead)  mr_cyc++;
      @(negedge clk);
    end
    check("ex_advance", 32'(adv), 32'd1);
  endtask

  task automatic bubble(input int cycles);
    Done_I = 1'b0;
    MCR    = 6'b11_1111;
    #1;
    check("stale_mcr_no_write", 32'(mem_if.MemWrite), 32'd0);
    check("stale_mcr_no_read", 32'(mem_if.MemRead), 32'd0);
    check("stale_mcr_no_stall", 32'(Feedback_Mem_Acc), 32'd0);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fb, mw, mr, acc0, dc0;

    rst_n = 1'b0; Done_I = 1'b0; PC_I = '0; MCR = '0; WDR = '0;
    ASR = '0; RAR = '0; F3R = '0;

    // load_extract reference unit checks
    ref_rdr = 32'h1180_2233; ref_off = 2'd0; ref_f3 = 3'b001; #1;
    check("ext_lh_low", ref_result, 32'h0000_2233);
    ref_off = 2'd3; ref_f3 = 3'b000; #1;
    check("ext_lb_off3", ref_result, 32'h0000_0011);
    ref_rdr = 32'h8000_00F0; ref_off = 2'd0; ref_f3 = 3'b011; #1;
    check("ext_other_f3", ref_result, 32'h8000_00F0);

    repeat (2) @(negedge clk);
    check("rst_done", 32'(Done_O), 32'd0);
    check("rst_pc", PC_O, 32'd0);
    check("rst_waddr", 32'(RF_waddr_O), 32'd0);
    check("rst_wdata", RF_wdata_O, 32'd0);
    check("rst_fb", 32'(Feedback_Mem_Acc), 32'd0);
    check("rst_memread", 32'(mem_if.MemRead), 32'd0);
    check("rst_memwrite", 32'(mem_if.MemWrite), 32'd0);
    check("rst_rdready", 32'(mem_if.Read_data_Ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU op passes through in one cycle without stalling
    issue(32'h100, 6'b00_0000, 32'h0, 32'h1234, 5'd5, 3'b000, 32'h1234, fb, mw, mr);
    check("alu_fb_cycles", 32'(fb), 32'd0);
    bubble(2);

    // SW with three-cycle request wait
    req_delay = 3;
    acc0 = accepts;
    issue(32'h104, 6'b10_1111, 32'hCAFE_F00D, 32'h1003, 5'd0, 3'b010, 32'h1003, fb, mw, mr);
    check("sw_address", mem_if.Address, 32'h1000);
    check("sw_strb", 32'(mem_if.Write_strb), 32'hF);
    check("sw_wdata", mem_if.Write_data, 32'hCAFE_F00D);
    check("sw_memwrite_cycles", 32'(mw), 32'd3);
    check("sw_fb_cycles", 32'(fb), 32'd4);
    bubble(2);
    check("sw_accepts", 32'(accepts - acc0), 32'd1);

    // Loads: data returned two cycles after accept
    req_delay = 1; rd_delay = 2; rd_word = 32'h1180_2233;
    issue(32'h108, 6'b01_0000, 32'h0, 32'h2002, 5'd7, 3'b000, 32'hFFFF_FF80, fb, mw, mr);
    check("lb_address", mem_if.Address, 32'h2000);
    check("lb_fb_cycles", 32'(fb), 32'd4);
    issue(32'h10C, 6'b01_0000, 32'h0, 32'h2002, 5'd8, 3'b100, 32'h0000_0080, fb, mw, mr);
    issue(32'h110, 6'b01_0000, 32'h0, 32'h2002, 5'd9, 3'b001, 32'h0000_1180, fb, mw, mr);
    rd_word = 32'h8000_1234;
    issue(32'h114, 6'b01_0000, 32'h0, 32'h2002, 5'd10, 3'b101, 32'h0000_8000, fb, mw, mr);
    issue(32'h118, 6'b01_0000, 32'h0, 32'h2000, 5'd11, 3'b010, 32'h8000_1234, fb, mw, mr);
    bubble(2);

    // Back-to-back load then ALU op: one request, results in order
    acc0 = accepts; dc0 = done_count; rd_word = 32'h0000_00FF;
    issue(32'h11C, 6'b01_0000, 32'h0, 32'h3000, 5'd12, 3'b000, 32'hFFFF_FFFF, fb, mw, mr);
    issue(32'h120, 6'b00_0000, 32'h0, 32'h5555, 5'd13, 3'b000, 32'h5555, fb, mw, mr);
    check("b2b_alu_no_stall", 32'(fb), 32'd0);
    bubble(3);
    check("b2b_single_request", 32'(accepts - acc0), 32'd1);
    check("b2b_done_pulses", 32'(done_count - dc0), 32'd2);

    // Spurious handshakes while idle
    dc0 = done_count; spur_valid = 1'b1; spur_ready = 1'b1;
    bubble(3);
    check("spur_idle_no_done", 32'(done_count - dc0), 32'd0);
    check("spur_idle_no_read", 32'(mem_if.MemRead), 32'd0);

    // Spurious valid during REQ_R must not short-cut the request
    spur_ready = 1'b0; req_delay = 3; rd_delay = 1; rd_word = 32'h0000_7F00;
    issue(32'h124, 6'b01_0000, 32'h0, 32'h4001, 5'd14, 3'b000, 32'h0000_007F, fb, mw, mr);
    check("spur_rr_memread_cycles", 32'(mr), 32'd3);
    spur_valid = 1'b0;
    bubble(2);

    // Reset in WAIT_RD abandons the load
    req_delay = 1; rd_delay = 50;
    Done_I = 1'b1; PC_I = 32'h200; MCR = 6'b01_0000; ASR = 32'h6000; RAR = 5'd3; F3R = 3'b010;
    fb = 0;
    for (int n = 0; n < 10 && fb == 0; n++) begin
      #1;
      if (mem_if.Read_data_Ready) fb = 1;
      else @(negedge clk);
    end
    check("rst_reached_wait_rd", 32'(fb), 32'd1);
    #2;
    rst_n = 1'b0; Done_I = 1'b0;
    #1;
    check("rst_async_rdready", 32'(mem_if.Read_data_Ready), 32'd0);
    check("rst_async_fb", 32'(Feedback_Mem_Acc), 32'd0);
    check("rst_async_done", 32'(Done_O), 32'd0);
    check("rst_async_pc", PC_O, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rd_delay = 1;
    @(negedge clk);
    issue(32'h300, 6'b00_0000, 32'h0, 32'h0BAD_0001, 5'd21, 3'b000, 32'h0BAD_0001, fb, mw, mr);
    bubble(3);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_mem_access.md
Name: stage_mem_access

Overview:
- Fourth pipeline stage (MEM): consumes the registered outputs of the execute stage and drives the data-memory request/response interface.
- Extracts and sign/zero-extends load data, and forwards a registered result to write-back.
- Drives Feedback_Mem_Acc, which freezes the execute stage (and everything upstream) while a memory access is outstanding.

Parameters:
- ALIGN_ADDR, 1: 1 = Address output has bits [1:0] forced to 0 (word-aligned bus); 0 = pass ASR unchanged.

Ports:
clk_I  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
Done_I  in  1  EX result valid
PC_I  in  32  PC of instruction in EX output regs
MCR  in  6  [5] MemW, [4] MemR, [3:0] Write_strb
WDR  in  32  store data, already lane-shifted
ASR  in  32  ALU/shift result or memory byte address
RAR  in  5  regfile write address (0 = no write)
F3R  in  3  funct3 of instruction
Address  out  32  memory address
MemWrite  out  1  write request
Write_data  out  32  = WDR
Write_strb  out  4  = MCR[3:0]
MemRead  out  1  read request
Mem_Req_Ready  in  1  memory accepts request this cycle
Read_data  in  32  load data
Read_data_Valid  in  1  load data valid
Read_data_Ready  out  1  stage accepts load data
Feedback_Mem_Acc  out  1  stall request to EX and upstream
Done_O  out  1  WB input valid
PC_O  out  32  PC to WB
RF_waddr_O  out  5  regfile write address to WB
RF_wdata_O  out  32  regfile write data to WB

Behaviour:
- FSM states: IDLE, REQ_W, REQ_R, WAIT_RD, DONE. Encoding is one-hot.
- memop = Done_I & (MCR[5] | MCR[4]). If both MCR bits are set (illegal), MemW takes priority.
- IDLE:
  - memop with MemW → REQ_W; memop with MemR only → REQ_R.
  - On the same edge, Done_O<=0 (bubble).
  - Otherwise Done_O<=Done_I; if Done_I, then PC_O<=PC_I, RF_waddr_O<=RAR, RF_wdata_O<=ASR. This is a 1-cycle pass-through for non-memory ops.
- REQ_W:
  - MemWrite=1.
  - Mem_Req_Ready=1 → DONE; otherwise hold.
- REQ_R:
  - MemRead=1.
  - Mem_Req_Ready=1 → WAIT_RD; otherwise hold.
- WAIT_RD:
  - Read_data_Ready=1.
  - Read_data_Valid=1 → capture Read_data into internal RDR, go to DONE.
- DONE:
  - Done_O<=1, PC_O<=PC_I, RF_waddr_O<=RAR.
  - RF_wdata_O<= extracted RDR for a load, ASR for a store.
  - Next state is IDLE unconditionally. EX has advanced on this same edge, so the op is never reissued.
- Done_O<=0 in REQ_W, REQ_R and WAIT_RD.
- Feedback_Mem_Acc = (IDLE & memop) | REQ_W | REQ_R | WAIT_RD.
  - Decoded from state and EX registers only; no memory-input terms, so the EX clock gate is glitch-safe.
  - Deasserted in DONE.
- MemWrite, MemRead and Read_data_Ready are decoded directly from state (Moore outputs).
- Address = ALIGN_ADDR ? {ASR[31:2],2'b00} : ASR. Write_data=WDR and Write_strb=MCR[3:0] continuously.
- Load extraction, using off=ASR[1:0]:
  - F3R=000 LB: byte at off, sign-extended.
  - 001 LH: half at ASR[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: half, zero-extended.
  - Other F3R values: full word.
- Latency:
  - Non-memory op: 1 cycle.
  - Store: 2 + wait cycles.
  - Load: 3 + request and data wait cycles.
- Read_data_Valid outside WAIT_RD is ignored. Mem_Req_Ready outside REQ_* is ignored.
- Done_I=0 with stale MCR bits: no request is issued.
- Reset (rst_n low, any time including mid-transaction):
  - state=IDLE, so MemRead, MemWrite, Read_data_Ready and Feedback_Mem_Acc drop immediately (combinationally).
  - Done_O=0, PC_O=0, RF_waddr_O=0, RF_wdata_O=0, RDR=0.
  - A pending transaction is abandoned; no response is awaited.

Decomposition:
- Shared package holds:
  - FSM state constants.
  - MCR bit-index constants (MCR_MEMW=5, MCR_MEMR=4, MCR_STRB=3:0).
  - Funct3 load-encoding constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
- One sub-module, load_extract: purely combinational (RDR, off, F3R → 32-bit result). It is reused by the bench's reference model.

Test Plan:
- ALU op: Done_I=1, MCR=0, ASR=0x1234, RAR=5 → next cycle Done_O=1, RF_wdata_O=0x1234, RF_waddr_O=5, Feedback_Mem_Acc never high.
- SW with 3-cycle Mem_Req_Ready delay, ASR=0x1003, MCR=6'b10_1111 → Address=0x1000, MemWrite high for exactly 3 cycles until ready, Feedback_Mem_Acc high from first cycle through ready cycle, Done_O=1 one cycle after DONE entry.
- LB at ASR=0x2002, Read_data=0x11_80_22_33 returned 2 cycles after accept → RF_wdata_O=0xFFFFFF80; repeat as LBU → 0x00000080; LH at ASR[1]=1 → 0x00001180.
- Back-to-back load then ALU op: ALU op held in EX during stall, Done_O sequence 0,0,...,1(load),1(ALU), with no duplicate memory request.
- Spurious Read_data_Valid=1 in IDLE and REQ_R → no capture, no state change; Mem_Req_Ready=1 while IDLE → no effect.
- rst_n pulled low in WAIT_RD → Read_data_Ready and Feedback_Mem_Acc go 0 asynchronously, Done_O=0; after release, a new ALU op completes normally.
